// File: rtl/mdpath_mem_hs.sv
// Multi-cycle MIPS datapath with a req/ack memory sequencer, stall output and
// ack timeout. Register-file depth, reset PC and timeout are parameters.
// Optional shifter (SLL/SRL ops and the shamt A-operand) is built only when
// MDP_SHIFT_EN is defined; otherwise those ops return 0.
module mdpath_mem_hs #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  RegDst,
    input  logic [1:0]  MemtoReg,
    input  logic [1:0]  ALUSrcA,
    input  logic [2:0]  ALUSrcB,
    input  logic [1:0]  PCSource,
    input  logic [2:0]  ALU_operation,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        mem_err,
    output logic [31:0] PC_Current,
    output logic [31:0] Inst,
    output logic        zero,
    output logic        overflow
);
    localparam int RA_W = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [31:0] pc, ir, mdr, alu_out;
    logic [31:0] regs [NREGS];
    logic [31:0] to_cnt, addr_q, wdata_q;
    logic        we_q, err_q;
    logic        mem_go, ack_hit, to_hit, pc_ld, rf_we;
    logic [4:0]  rs_a, rt_a, rd_a, wr_a;
    logic [31:0] rs_v, rt_v, wr_v, alu_a, alu_b, alu_y, pc_nx, imm_s, imm_z;

    assign rs_a  = ir[25:21];
    assign rt_a  = ir[20:16];
    assign rd_a  = ir[15:11];
    assign imm_s = {{16{ir[15]}}, ir[15:0]};
    assign imm_z = {16'h0, ir[15:0]};

    // Registers beyond NREGS (and r0) read as zero
    assign rs_v = (rs_a != 5'd0 && 32'(rs_a) < NREGS) ? regs[rs_a[RA_W-1:0]] : 32'h0;
    assign rt_v = (rt_a != 5'd0 && 32'(rt_a) < NREGS) ? regs[rt_a[RA_W-1:0]] : 32'h0;

    // Sequencer next state; stall covers the request cycle and all of BUSY
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        mem_go   = 1'b0;
        ack_hit  = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE: if (MemRead | MemWrite) begin
                mem_go   = 1'b1;
                stall    = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    ack_hit  = 1'b1;
                    state_nx = DONE;
                end else if (TIMEOUT != 0 && to_cnt == 32'(TIMEOUT - 1)) begin
                    to_hit   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer state, latched request and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            to_cnt  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (mem_go) begin
                addr_q  <= IorD ? alu_out : pc;
                wdata_q <= rt_v;
                we_q    <= MemWrite;
                to_cnt  <= '0;
            end else if (state == BUSY) begin
                to_cnt <= to_cnt + 32'd1;
            end
            if (to_hit) err_q <= 1'b1;
        end
    end

    // MDR/IR load only when a read completes with ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdr <= '0;
            ir  <= '0;
        end else if (ack_hit && !we_q) begin
            mdr <= mem_rdata;
            if (IRWrite) ir <= mem_rdata;
        end
    end

    // A-operand mux; shamt source exists only with the shifter
    always_comb begin
        alu_a = pc;
        case (ALUSrcA)
            2'd0: alu_a = pc;
            2'd1: alu_a = rs_v;
            2'd2: alu_a = rt_v;
`ifdef MDP_SHIFT_EN
            2'd3: alu_a = {27'h0, ir[10:6]};
`else
            2'd3: alu_a = 32'h0;
`endif
            default: alu_a = pc;
        endcase
    end

    // B-operand mux
    always_comb begin
        alu_b = 32'h0;
        case (ALUSrcB)
            3'd0:    alu_b = rt_v;
            3'd1:    alu_b = 32'd4;
            3'd2:    alu_b = imm_s;
            3'd3:    alu_b = imm_z;
            3'd4:    alu_b = {imm_s[29:0], 2'b00};
            default: alu_b = 32'h0;
        endcase
    end

    // ALU; overflow reported for ADD/SUB only
    always_comb begin
        alu_y    = 32'h0;
        overflow = 1'b0;
        case (ALU_operation)
            3'b000: alu_y = alu_a & alu_b;
            3'b001: alu_y = alu_a | alu_b;
            3'b010: begin
                alu_y    = alu_a + alu_b;
                overflow = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            3'b110: begin
                alu_y    = alu_a - alu_b;
                overflow = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            3'b111: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
            3'b100: alu_y = ~(alu_a | alu_b);
`ifdef MDP_SHIFT_EN
            3'b011: alu_y = alu_b << alu_a[4:0];
            3'b101: alu_y = alu_b >> alu_a[4:0];
`endif
            default: alu_y = 32'h0;
        endcase
    end

    assign zero = (alu_y == 32'h0);

    // Next-PC source, register-file write address and write data
    always_comb begin
        pc_nx = alu_y;
        case (PCSource)
            2'd0: pc_nx = alu_y;
            2'd1: pc_nx = alu_out;
            2'd2: pc_nx = {pc[31:28], ir[25:0], 2'b00};
            2'd3: pc_nx = rs_v;
            default: pc_nx = alu_y;
        endcase
        wr_a = 5'd0;
        case (RegDst)
            2'd0:    wr_a = rt_a;
            2'd1:    wr_a = rd_a;
            2'd2:    wr_a = 5'd31;
            default: wr_a = 5'd0;
        endcase
        wr_v = alu_out;
        case (MemtoReg)
            2'd0: wr_v = alu_out;
            2'd1: wr_v = mdr;
            2'd2: wr_v = {ir[15:0], 16'h0};
            2'd3: wr_v = pc;
            default: wr_v = alu_out;
        endcase
    end

    assign pc_ld = (((zero == Branch) & PCWriteCond) | PCWrite) & ~stall;
    assign rf_we = RegWrite & ~stall & (wr_a != 5'd0) & (32'(wr_a) < NREGS);

    // PC and ALUOut hold while the controller is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            alu_out <= '0;
        end else if (!stall) begin
            alu_out <= alu_y;
            if (pc_ld) pc <= pc_nx;
        end
    end

    // Register file: synchronous write, so same-cycle reads see the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[wr_a[RA_W-1:0]] <= wr_v;
        end
    end

    assign mem_req    = (state == BUSY);
    assign mem_we     = we_q & mem_req;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_err    = err_q;
    assign PC_Current = pc;
    assign Inst       = ir;
endmodule

// File: tb/tb_mdpath_mem_hs.sv
// Self-checking bench for mdpath_mem_hs (NREGS=8, RESET_PC=0x100, TIMEOUT=4).
module tb_mdpath_mem_hs;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, MemRead, MemWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, PCSource;
    logic [2:0]  ALUSrcB, ALU_operation;
    logic        mem_req, mem_we, mem_ack, stall, mem_err, zero, overflow;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC_Current, Inst;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } mreq_t;

    mreq_t       req_q[$];
    logic [31:0] val_q[$];
    int          n_run = 0;
    int          n_fail = 0;

    int          obs_stall, obs_busy;
    logic        obs_stable, obs_done;
    mreq_t       obs_req;

    always #5 clk = ~clk;

    mdpath_mem_hs #(.NREGS(8), .RESET_PC(RPC), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .mem_err(mem_err),
        .PC_Current(PC_Current), .Inst(Inst), .zero(zero), .overflow(overflow)
    );

    function automatic mreq_t mk(input logic [31:0] a, input logic [31:0] w, input logic we);
        mreq_t r;
        r.addr = a; r.wdata = w; r.we = we;
        return r;
    endfunction

    task automatic ctl_clear();
        IorD = 0; IRWrite = 0; RegWrite = 0; PCWrite = 0; PCWriteCond = 0; Branch = 0;
        MemRead = 0; MemWrite = 0; RegDst = 0; MemtoReg = 0; ALUSrcA = 0; ALUSrcB = 0;
        PCSource = 0; ALU_operation = 0;
    endtask

    // one non-stalled step with the controls currently driven
    task automatic tick();
        @(posedge clk); #1;
        ctl_clear();
    endtask

    // run one memory step with the controls currently driven; ack after 'waits' BUSY cycles
    task automatic access(input int waits, input logic [31:0] rdata, input bit ack_en);
        obs_stall = 0; obs_busy = 0; obs_stable = 1; obs_done = 0;
        obs_req = mk(32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            mem_ack = 0;
            if (!stall) begin
                obs_done = 1;
                break;
            end
            obs_stall++;
            if (mem_req) begin
                if (obs_busy == 0) obs_req = mk(mem_addr, mem_wdata, mem_we);
                else if (mem_addr !== obs_req.addr || mem_wdata !== obs_req.wdata ||
                         mem_we !== obs_req.we) obs_stable = 0;
                if (ack_en && obs_busy == waits) begin
                    mem_ack   = 1;
                    mem_rdata = rdata;
                end
                obs_busy++;
            end
        end
        mem_ack = 0;
        if (!obs_done) begin
            n_run++; n_fail++;
            $display("FAIL access_bound: stall never released within 40 cycles");
        end
        @(posedge clk); #1;
        ctl_clear();
    endtask

    task automatic fetch(input logic [31:0] word);
        ctl_clear();
        MemRead = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 3'd1; ALU_operation = 3'b010;
        access(0, word, 1);
    endtask

    // rt <- zext(imm) (rs must be r0); returns zero flag seen while the write is pending
    task automatic set_rt_imm(output logic z_old);
        ALUSrcA = 2'd1; ALUSrcB = 3'd3; ALU_operation = 3'b010;
        tick();
        RegWrite = 1; RegDst = 2'd0; MemtoReg = 2'd0;
        ALUSrcA = 2'd2; ALUSrcB = 3'd5; ALU_operation = 3'b001;
        @(negedge clk); z_old = zero;
        tick();
    endtask

    // PC <- rt | 0, exposing the register value on PC_Current
    task automatic read_rt(output logic [31:0] v, output logic z);
        ALUSrcA = 2'd2; ALUSrcB = 3'd5; ALU_operation = 3'b001; PCWrite = 1; PCSource = 2'd0;
        @(negedge clk); z = zero;
        tick();
        v = PC_Current;
    endtask

    task automatic test_reset();
        reset = 1; ctl_clear(); mem_ack = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_run++; if (PC_Current !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC_Current, RPC); end
        n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_run++; if (Inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", Inst); end
        n_run++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
        n_run++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: we %b addr %h wdata %h want 0", mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        mreq_t e;
        req_q.push_back(mk(RPC, 32'h0, 1'b0));
        ctl_clear();
        MemRead = 1; IRWrite = 1; PCWrite = 1; ALUSrcB = 3'd1; ALU_operation = 3'b010;
        access(2, 32'h2008_0005, 1);
        e = req_q.pop_front();
        n_run++; if (obs_req.addr !== e.addr || obs_req.we !== e.we || obs_req.wdata !== e.wdata) begin
            n_fail++; $display("FAIL fetch_req: got %h/%h/%b want %h/%h/%b", obs_req.addr, obs_req.wdata, obs_req.we, e.addr, e.wdata, e.we);
        end
        n_run++; if (obs_stall != 4) begin n_fail++; $display("FAIL fetch_stall_cycles: got %0d want 4", obs_stall); end
        n_run++; if (obs_busy != 3) begin n_fail++; $display("FAIL fetch_busy_cycles: got %0d want 3", obs_busy); end
        n_run++; if (Inst !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_inst: got %h want 20080005", Inst); end
        n_run++; if (PC_Current !== RPC + 32'd4) begin n_fail++; $display("FAIL fetch_pc: got %h want %h", PC_Current, RPC + 32'd4); end
    endtask

    task automatic test_sw();
        mreq_t e;
        logic [31:0] v;
        logic z;
        fetch(32'h8C02_0040);
        ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALU_operation = 3'b010;
        tick();
        ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALU_operation = 3'b010; IorD = 1; MemRead = 1;
        req_q.push_back(mk(32'h40, 32'h0, 1'b0));
        access(1, 32'hDEAD_BEEF, 1);
        e = req_q.pop_front();
        n_run++; if (obs_req.addr !== e.addr || obs_req.we !== e.we || obs_req.wdata !== e.wdata) begin
            n_fail++; $display("FAIL lw_req: got %h/%h/%b want %h/%h/%b", obs_req.addr, obs_req.wdata, obs_req.we, e.addr, e.wdata, e.we);
        end
        ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALU_operation = 3'b010;
        RegWrite = 1; RegDst = 2'd0; MemtoReg = 2'd1;
        tick();
        ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALU_operation = 3'b010; IorD = 1; MemWrite = 1;
        req_q.push_back(mk(32'h40, 32'hDEAD_BEEF, 1'b1));
        access(3, 32'h0, 1);
        e = req_q.pop_front();
        n_run++; if (obs_req.addr !== e.addr || obs_req.we !== e.we || obs_req.wdata !== e.wdata) begin
            n_fail++; $display("FAIL sw_req: got %h/%h/%b want %h/%h/%b", obs_req.addr, obs_req.wdata, obs_req.we, e.addr, e.wdata, e.we);
        end
        n_run++; if (obs_stable !== 1'b1 || obs_busy != 4) begin
            n_fail++; $display("FAIL sw_hold: stable %b busy %0d want 1 and 4", obs_stable, obs_busy);
        end
        val_q.push_back(32'hDEAD_BEEF);
        read_rt(v, z);
        n_run++; if (v !== val_q[0]) begin n_fail++; $display("FAIL sw_reg_kept: got %h want %h", v, val_q[0]); end
        void'(val_q.pop_front());
        n_run++; if (Inst !== 32'h8C02_0040) begin n_fail++; $display("FAIL sw_inst_kept: got %h want 8c020040", Inst); end
    endtask

    task automatic test_nregs();
        logic [31:0] ins [3];
        logic [31:0] exp [3];
        logic [31:0] v, e;
        logic z, zo;
        ins = '{32'h2009_0055, 32'h2000_0055, 32'h2003_0055};
        exp = '{32'h0, 32'h0, 32'h55};
        for (int i = 0; i < 3; i++) begin
            fetch(ins[i]);
            set_rt_imm(zo);
            val_q.push_back(exp[i]);
            read_rt(v, z);
            e = val_q.pop_front();
            n_run++; if (v !== e) begin n_fail++; $display("FAIL nregs_read[%0d]: got %h want %h", i, v, e); end
            n_run++; if (zo !== 1'b1) begin n_fail++; $display("FAIL nregs_old_on_write[%0d]: zero %b want 1", i, zo); end
            n_run++; if (z !== (e == 32'h0)) begin n_fail++; $display("FAIL nregs_zero[%0d]: got %b want %b", i, z, e == 32'h0); end
        end
    endtask

    task automatic test_overflow();
        fetch(32'h2002_0001);
        IorD = 1; MemRead = 1;
        access(0, 32'h7FFF_FFFF, 1);
        RegWrite = 1; RegDst = 2'd0; MemtoReg = 2'd1;
        tick();
        ALUSrcA = 2'd2; ALUSrcB = 3'd2; ALU_operation = 3'b010; PCWrite = 1;
        @(negedge clk);
        n_run++; if (overflow !== 1'b1 || zero !== 1'b0) begin
            n_fail++; $display("FAIL add_ovf: ovf %b zero %b want 1 0", overflow, zero);
        end
        tick();
        n_run++; if (PC_Current !== 32'h8000_0000) begin n_fail++; $display("FAIL add_wrap: got %h want 80000000", PC_Current); end
        ALUSrcA = 2'd2; ALUSrcB = 3'd2; ALU_operation = 3'b001;
        @(negedge clk);
        n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL or_no_ovf: got %b want 0", overflow); end
        tick();
        ALUSrcA = 2'd0; ALUSrcB = 3'd2; ALU_operation = 3'b110;
        @(negedge clk);
        n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %b want 1", overflow); end
        tick();
        ALUSrcA = 2'd2; ALUSrcB = 3'd2; ALU_operation = 3'b110;
        @(negedge clk);
        n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sub_no_ovf: got %b want 0", overflow); end
        tick();
    endtask

    task automatic test_shift();
        logic zo, z, ez;
        logic [31:0] e;
        fetch(32'h2003_0001);
        set_rt_imm(zo);
        fetch(32'h0003_2900);
        ALUSrcA = 2'd3; ALUSrcB = 3'd0; ALU_operation = 3'b011; PCWrite = 1; PCSource = 2'd0;
`ifdef MDP_SHIFT_EN
        val_q.push_back(32'h10); ez = 1'b0;
`else
        val_q.push_back(32'h0);  ez = 1'b1;
`endif
        @(negedge clk); z = zero;
        tick();
        e = val_q.pop_front();
        n_run++; if (PC_Current !== e) begin n_fail++; $display("FAIL sll_result: got %h want %h", PC_Current, e); end
        n_run++; if (z !== ez) begin n_fail++; $display("FAIL sll_zero: got %b want %b", z, ez); end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        logic z;
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0; IRWrite = 1;
        tick();
        mem_ack = 0;
        n_run++; if (Inst !== 32'h0003_2900) begin n_fail++; $display("FAIL stray_ack: got %h want 00032900", Inst); end
        MemRead = 1; IRWrite = 1;
        access(0, 32'hBAD0_BAD0, 0);
        n_run++; if (obs_busy != 4 || obs_stall != 5) begin
            n_fail++; $display("FAIL timeout_len: busy %0d stall %0d want 4 5", obs_busy, obs_stall);
        end
        n_run++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", mem_err); end
        n_run++; if (Inst !== 32'h0003_2900) begin n_fail++; $display("FAIL timeout_ir: got %h want 00032900", Inst); end
        RegWrite = 1; RegDst = 2'd0; MemtoReg = 2'd1;
        tick();
        val_q.push_back(32'h0003_2900);
        read_rt(v, z);
        n_run++; if (v !== val_q[0]) begin n_fail++; $display("FAIL timeout_mdr: got %h want %h", v, val_q[0]); end
        void'(val_q.pop_front());
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", mem_err); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        MemRead = 1; IRWrite = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin seen = 1; break; end
        end
        n_run++; if (!seen) begin n_fail++; $display("FAIL rstmid_req: mem_req never rose within 10 cycles"); end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        #2 reset = 1;
        #1;
        n_run++; if (mem_req !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: req %b err %b want 0 0", mem_req, mem_err);
        end
        @(posedge clk); #1;
        reset = 0; mem_ack = 0; ctl_clear();
        @(negedge clk);
        n_run++; if (Inst !== 32'h0 || PC_Current !== RPC || stall !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: inst %h pc %h stall %b want 0 %h 0", Inst, PC_Current, stall, RPC);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_sw();
        test_nregs();
        test_overflow();
        test_shift();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mdpath_mem_hs.md
# mdpath_mem_hs

Parametrised multi-cycle MIPS datapath for the Flappy-Bird CPU, driven step-by-step by the existing multi-cycle controller. It replaces the always-ready memory assumption with a req/ack memory handshake, a stall output to the controller and an ack timeout. It also adds a configurable register-file depth, a configurable reset PC and an optional shifter. It sits between the controller and the MIO bus.

## Interface
- NREGS, 32, register-file depth: 8, 16 or 32
- RESET_PC, 32'h0000_0000, PC value after reset
- TIMEOUT, 255, maximum BUSY cycles without `mem_ack`; 0 disables the timeout
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch  in  1 each  controller strobes, same meaning as in the previous datapath
- MemRead, MemWrite  in  1 each  request a memory access this step
- RegDst  in  2  0 = rt, 1 = rd, 2 = r31
- MemtoReg  in  2  0 = ALUOut, 1 = MDR, 2 = {imm16, 16'b0}, 3 = PC
- ALUSrcA  in  2  0 = PC, 1 = rs, 2 = rt, 3 = shamt (see Configuration)
- ALUSrcB  in  3  0 = rt, 1 = 4, 2 = sext(imm), 3 = zext(imm), 4 = sext(imm) << 2, 5–7 = 0
- PCSource  in  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
- ALU_operation  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 100 NOR, 011/101 shift
- mem_req  out  1  access in progress
- mem_we  out  1  write access
- mem_addr  out  32  access address, held while `mem_req` is high
- mem_wdata  out  32  write data (rt), held while `mem_req` is high
- mem_rdata  in  32  read data, sampled on the `mem_ack` cycle
- mem_ack  in  1  one-cycle completion strobe
- stall  out  1  controller must hold its current step
- mem_err  out  1  sticky timeout flag
- PC_Current, Inst  out  32 each  PC and IR
- zero, overflow  out  1 each  combinational ALU flags

## Operation
Memory sequencer FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - If `MemRead | MemWrite`: latch the address (from the IorD mux), `mem_wdata` and `mem_we`; clear the timeout counter; go to BUSY.
  - `stall` = 1 in this cycle.
- BUSY:
  - `mem_req` = 1; `stall` = 1.
  - On `mem_ack`:
    - For a read, MDR ← `mem_rdata`, and IR ← `mem_rdata` if IRWrite is high.
    - Go to DONE.
  - Otherwise, if TIMEOUT ≠ 0 and the counter reaches TIMEOUT: set `mem_err`, leave MDR/IR unchanged, go to DONE.
- DONE: `stall` = 0 for one cycle; no new request is accepted in this cycle; go to IDLE.
- `stall` = (state == BUSY) | (state == IDLE & (MemRead | MemWrite)).

Architectural updates are gated by `~stall`:
- PC loads when `((zero == Branch) & PCWriteCond) | PCWrite`.
- Register file writes when RegWrite is high.
- ALUOut loads the ALU result every non-stalled cycle.
- IR loads only through the memory path (BUSY + ack).

Register file:
- r0 reads as 0; writes to r0 are ignored.
- Addresses ≥ NREGS read 0 and their writes are dropped; this includes RegDst = 2 when NREGS < 32.
- Two combinational read ports (rs, rt); synchronous write port.

ALU:
- ADD/SUB use 32-bit wrap arithmetic.
- `overflow` is signed overflow for ADD/SUB only and is 0 for all other ops.
- `zero` = (result == 0).
- Jump target = {PC[31:28], Inst[25:0], 2'b00}.

## Timing
- Reset values:
  - PC = RESET_PC.
  - IR, MDR, ALUOut and all registers = 0.
  - FSM = IDLE; `mem_req` = `mem_we` = `stall` = `mem_err` = 0.
  - `mem_addr` = `mem_wdata` = 0.
- Minimum memory step is 3 cycles: IDLE(stall) → BUSY with ack → DONE.
- Each extra wait cycle adds one BUSY cycle.
- `mem_ack` outside BUSY is ignored.
- Reset asserted mid-access: `mem_req` drops asynchronously and no MDR/IR update occurs.
- Simultaneous RegWrite and a register read of the same address: the read returns the old value; the new value is visible next cycle.

## Configuration
- MDP_SHIFT_EN defined:
  - ALU_operation 011 = SLL (B << A[4:0]).
  - ALU_operation 101 = SRL (B >> A[4:0], logical).
  - ALUSrcA = 3 selects {27'b0, Inst[10:6]}.
- MDP_SHIFT_EN undefined:
  - ALU ops 011/101 give result 0 (`zero` = 1).
  - ALUSrcA = 3 selects 0.
  - No shifter logic is synthesised.

## Test plan
- Reset with RESET_PC = 32'h0000_0100 → PC_Current = 0x100, `mem_req` = 0, `stall` = 0; Inst = 0 after reset release.
- Fetch step (IorD = 0, MemRead, IRWrite, PCWrite, ALUSrcB = 1, ADD), ack after 2 wait cycles with rdata = 0x2008_0005 → `stall` high for 4 cycles, Inst = 0x2008_0005, PC = 0x104 after DONE.
- `sw` with rt = 0xDEAD_BEEF, ALUOut = 0x40 → `mem_we` = 1, `mem_addr` = 0x40, `mem_wdata` = 0xDEAD_BEEF held stable until ack; registers unchanged.
- TIMEOUT = 4, ack never returned → `mem_req` falls after 4 BUSY cycles, `mem_err` = 1 and stays 1, MDR unchanged.
- NREGS = 8: write 0x55 to r9 and to r0, then read both → both read 0; write to r3 reads back 0x55. ADD 0x7FFF_FFFF + 1 → `overflow` = 1.
- With MDP_SHIFT_EN, SLL with shamt = 4 on rt = 0x1 → result 0x10; without the macro, the same op → result 0, `zero` = 1.
